// File: rtl/lowf_fir_mac_if.sv
// Stream/ROM bundle between the low-frequency queue, the coefficient ROM and
// the FIR MAC engine.
//   master : queue/ROM side. Drives sequencing, smpl_in and coeff. Observes
//            coeff_addr and the result signals.
//   slave  : FIR MAC side. Consumes the stream and coefficients. Drives
//            coeff_addr, smpl_out, smpl_vld, busy and abort.
interface lowf_fir_mac_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              sequencing;  // queue read window active
  logic [15:0]       smpl_in;     // signed sample, one cycle after its read
  logic [15:0]       coeff;       // signed Q1.15 coefficient, 1-cycle ROM latency
  logic [ADDR_W-1:0] coeff_addr;  // registered ROM address
  logic [15:0]       smpl_out;    // signed filtered sample, held until next result
  logic              smpl_vld;    // one-cycle pulse when smpl_out updates
  logic              busy;        // window in progress
  logic              abort;       // one-cycle pulse when a window is dropped

  modport master (
    output sequencing, smpl_in, coeff,
    input  coeff_addr, smpl_out, smpl_vld, busy, abort
  );

  modport slave (
    input  sequencing, smpl_in, coeff,
    output coeff_addr, smpl_out, smpl_vld, busy, abort
  );
endinterface

// File: rtl/lowf_fir_mac.sv
// Single-multiplier FIR engine for the low-frequency band. It does one MAC per
// clock while the queue streams a read window. Each sample is multiplied by a
// Q1.15 coefficient from an external ROM and the products are accumulated. At
// the end of the window one saturated 16-bit sample is emitted.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : lowf_fir_mac_if slave modport. Inputs are sequencing, smpl_in and
//         coeff. Outputs are coeff_addr, smpl_out, smpl_vld, busy and abort.
// NUM_TAPS must be at least 2, 2**ADDR_W >= NUM_TAPS and
// ACC_W >= 32 + clog2(NUM_TAPS). Under these limits the accumulator cannot wrap.
module lowf_fir_mac #(
  parameter int unsigned NUM_TAPS = 1021,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned ACC_W    = 42
) (
  input  logic          clk,
  input  logic          rst,
  lowf_fir_mac_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StMac, StRound, StOut} state_e;

  localparam logic [ADDR_W-1:0]       LastTap = ADDR_W'(NUM_TAPS - 1);
  localparam logic signed [ACC_W-1:0] SatHi   = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SatLo   = ACC_W'(-32'sd32768);

  state_e                   state_q, state_d;
  logic                     seq_d_q;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [ADDR_W-1:0]        tap_q, tap_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [15:0]              smpl_out_q, smpl_out_d;
  logic                     vld_q, vld_d;
  logic                     busy_q, busy_d;
  logic                     abort_q, abort_d;

  logic                     start;
  logic signed [15:0]       smpl_s, coeff_s;
  logic signed [31:0]       prod;
  logic signed [ACC_W-1:0]  shr;
  logic [15:0]              sat;

  assign start   = bus.sequencing & ~seq_d_q;
  assign smpl_s  = bus.smpl_in;
  assign coeff_s = bus.coeff;
  assign prod    = 32'(smpl_s) * 32'(coeff_s);

  // Drop the Q1.15 fraction with an arithmetic shift, which truncates toward
  // -inf. Then clamp to the 16-bit signed range.
  assign shr = acc_q >>> 15;
  always_comb begin
    sat = shr[15:0];
    if (shr > SatHi) begin
      sat = 16'h7FFF;
    end else if (shr < SatLo) begin
      sat = 16'h8000;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tap_d      = tap_q;
    acc_d      = acc_q;
    smpl_out_d = smpl_out_q;
    vld_d      = 1'b0;
    abort_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        addr_d = '0;
        tap_d  = '0;
        acc_d  = '0;
        // Address 0 is presented in the start cycle itself, so the ROM output
        // lines up with the first sample one cycle later.
        if (start) begin
          addr_d  = ADDR_W'(1);
          state_d = StMac;
        end
      end
      StMac: begin
        if (!bus.sequencing) begin
          abort_d = 1'b1;
          addr_d  = '0;
          tap_d   = '0;
          acc_d   = '0;
          state_d = StIdle;
        end else begin
          acc_d = acc_q + ACC_W'(prod);
          if (addr_q != LastTap) begin
            addr_d = addr_q + ADDR_W'(1);
          end
          if (tap_q == LastTap) begin
            tap_d   = '0;
            state_d = StRound;
          end else begin
            tap_d = tap_q + ADDR_W'(1);
          end
        end
      end
      StRound: begin
        smpl_out_d = sat;
        vld_d      = 1'b1;
        state_d    = StOut;
      end
      StOut: begin
        acc_d   = '0;
        addr_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      seq_d_q    <= 1'b0;
      addr_q     <= '0;
      tap_q      <= '0;
      acc_q      <= '0;
      smpl_out_q <= '0;
      vld_q      <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_d_q    <= bus.sequencing;
      addr_q     <= addr_d;
      tap_q      <= tap_d;
      acc_q      <= acc_d;
      smpl_out_q <= smpl_out_d;
      vld_q      <= vld_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.coeff_addr = addr_q;
  assign bus.smpl_out   = smpl_out_q;
  assign bus.smpl_vld   = vld_q;
  assign bus.busy       = busy_q;
  assign bus.abort      = abort_q;

endmodule
